// File: rtl/dfs_ctrl.sv
// dfs_ctrl: job sequencer for the 4-level depth-first sphere-decoding engine.
// Accepts tagged jobs, runs the engine by releasing its active-low reset,
// captures the best symbol vector on completion or aborts on a cycle budget,
// and returns tagged results through a single-entry result slot.
module dfs_ctrl #(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned MAX_CYCLES = 16'd8192
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [ID_W-1:0]  job_id,
    output logic             eng_reset,
    input  logic             eng_done,
    input  logic [2:0]       eng_best0,
    input  logic [2:0]       eng_best1,
    input  logic [2:0]       eng_best2,
    input  logic [2:0]       eng_best3,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ID_W-1:0]  res_id,
    output logic [11:0]      res_sym,
    output logic [CYC_W-1:0] res_cycles,
    output logic             res_timeout
);

    localparam logic [CYC_W-1:0] MAX_CNT = CYC_W'(MAX_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_cnt_next;
    logic [ID_W-1:0]  cur_id;
    logic [11:0]      best_vec;

    assign best_vec = {eng_best3, eng_best2, eng_best1, eng_best0};

    // Saturating increment of the RUN cycle counter
    always_comb begin
        cyc_cnt_next = cyc_cnt;
        if (cyc_cnt != '1) begin
            cyc_cnt_next = cyc_cnt + CYC_W'(1);
        end
    end

    // Accept only when idle and the result slot is free or draining this cycle
    always_comb begin
        job_ready = 1'b0;
        if (state == IDLE) begin
            job_ready = !res_valid || res_ready;
        end
    end

    // Job FSM, engine reset control and result slot
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            cur_id      <= '0;
            eng_reset   <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_sym     <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            // Pop first; a capture later in this block overrides it on the same edge
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        cur_id    <= job_id;
                        cyc_cnt   <= '0;
                        eng_reset <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    cyc_cnt <= cyc_cnt_next;
                    if (eng_done) begin
                        res_valid   <= 1'b1;
                        res_id      <= cur_id;
                        res_sym     <= best_vec;
                        res_cycles  <= cyc_cnt_next;
                        res_timeout <= 1'b0;
                        eng_reset   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (cyc_cnt_next == MAX_CNT) begin
                        res_valid   <= 1'b1;
                        res_id      <= cur_id;
                        res_sym     <= best_vec;
                        res_cycles  <= MAX_CNT;
                        res_timeout <= 1'b1;
                        eng_reset   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    eng_reset <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfs_ctrl.sv
// tb_dfs_ctrl: directed test of dfs_ctrl against a transaction-level model,
// with an engine stub driven from the stimulus process.
module tb_dfs_ctrl;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned CYC_W = 16;
    localparam int unsigned MAXC  = 25;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             job_valid;
    logic             job_ready;
    logic [ID_W-1:0]  job_id;
    logic             eng_reset;
    logic             eng_done;
    logic [2:0]       eng_best0, eng_best1, eng_best2, eng_best3;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic [11:0]      res_sym;
    logic [CYC_W-1:0] res_cycles;
    logic             res_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    dfs_ctrl #(.ID_W(ID_W), .CYC_W(CYC_W), .MAX_CYCLES(MAXC)) dut (
        .Clk(Clk), .Reset(Reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .eng_reset(eng_reset), .eng_done(eng_done),
        .eng_best0(eng_best0), .eng_best1(eng_best1),
        .eng_best2(eng_best2), .eng_best3(eng_best3),
        .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sym(res_sym), .res_cycles(res_cycles), .res_timeout(res_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: job in flight plus one result slot ----------------
    bit        m_run = 0;
    int        m_elapsed = 0;
    int        m_id = 0;
    bit        m_valid = 0;
    int        m_rid = 0;
    int        m_sym = 0;
    int        m_cycles = 0;
    bit        m_to = 0;
    bit        m_seen_edge = 0;

    always @(posedge Clk) begin
        bit ready_now;
        ready_now = !m_run && (!m_valid || res_ready);
        m_seen_edge = 1;
        if (!Reset) begin
            m_run = 0; m_elapsed = 0; m_valid = 0;
            m_rid = 0; m_sym = 0; m_cycles = 0; m_to = 0;
        end else begin
            if (m_valid && res_ready) m_valid = 0;
            if (m_run) begin
                m_elapsed = m_elapsed + 1;
                if (eng_done || m_elapsed == MAXC) begin
                    m_valid  = 1;
                    m_rid    = m_id;
                    m_sym    = eng_best3 * 512 + eng_best2 * 64 + eng_best1 * 8 + eng_best0;
                    m_cycles = eng_done ? m_elapsed : MAXC;
                    m_to     = !eng_done;
                    m_run    = 0;
                end
            end else if (job_valid && ready_now) begin
                m_run = 1;
                m_elapsed = 0;
                m_id = job_id;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge Clk) begin
        #1;
        if (m_seen_edge) begin
            chk("eng_reset",   32'(eng_reset),   32'(m_run));
            chk("busy",        32'(busy),        32'(m_run));
            chk("job_ready",   32'(job_ready),   32'(!m_run && (!m_valid || res_ready)));
            chk("res_valid",   32'(res_valid),   32'(m_valid));
            chk("res_id",      32'(res_id),      32'(m_rid));
            chk("res_sym",     32'(res_sym),     32'(m_sym));
            chk("res_cycles",  32'(res_cycles),  32'(m_cycles));
            chk("res_timeout", 32'(res_timeout), 32'(m_to));
        end
    end

    // ---------------- stimulus helpers (all driven at negedge) ----------------
    task automatic set_best(input logic [2:0] b3, b2, b1, b0);
        eng_best3 = b3; eng_best2 = b2; eng_best1 = b1; eng_best0 = b0;
    endtask

    // Offer a job; returns at the negedge inside RUN cycle 1
    task automatic offer(input logic [ID_W-1:0] id);
        bit acc;
        acc = 0;
        @(negedge Clk);
        job_valid = 1'b1;
        job_id = id;
        for (int k = 0; k < 60; k++) begin
            #1;
            acc = job_ready;
            @(negedge Clk);
            if (acc) break;
        end
        job_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: job %0d never accepted", id);
        end
    endtask

    // From RUN cycle 1, pulse eng_done in cycle n with the given best vector
    task automatic done_at(input int n, input logic [2:0] b3, b2, b1, b0);
        repeat (n - 1) @(negedge Clk);
        eng_done = 1'b1;
        set_best(b3, b2, b1, b0);
        @(negedge Clk);
        eng_done = 1'b0;
        set_best(3'd0, 3'd0, 3'd0, 3'd0);
    endtask

    initial begin
        Reset = 1'b0; job_valid = 1'b0; job_id = '0; eng_done = 1'b0;
        res_ready = 1'b0;
        set_best(3'd0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(negedge Clk);
        chk("lit_reset_job_ready", 32'(job_ready), 32'd1);
        chk("lit_reset_res_valid", 32'(res_valid), 32'd0);
        chk("lit_reset_eng_reset", 32'(eng_reset), 32'd0);
        Reset = 1'b1;

        // stray eng_done in IDLE is ignored
        @(negedge Clk);
        eng_done = 1'b1;
        @(negedge Clk);
        eng_done = 1'b0;

        // Job 3 completes in 9 cycles with all-zero best vector
        offer(4'd3);
        done_at(9, 3'd0, 3'd0, 3'd0, 3'd0);
        chk("lit_j3_valid",   32'(res_valid),   32'd1);
        chk("lit_j3_cycles",  32'(res_cycles),  32'd9);
        chk("lit_j3_sym",     32'(res_sym),     32'h000);
        chk("lit_j3_id",      32'(res_id),      32'd3);
        chk("lit_j3_timeout", 32'(res_timeout), 32'd0);
        chk("lit_j3_eng_rst", 32'(eng_reset),   32'd0);
        res_ready = 1'b1;
        @(negedge Clk);
        res_ready = 1'b0;

        // Job 7 never finishes: budget abort captures current best
        set_best(3'd3, 3'd3, 3'd3, 3'd3);
        offer(4'd7);
        repeat (MAXC) @(negedge Clk);
        chk("lit_j7_valid",   32'(res_valid),   32'd1);
        chk("lit_j7_cycles",  32'(res_cycles),  32'd25);
        chk("lit_j7_timeout", 32'(res_timeout), 32'd1);
        chk("lit_j7_id",      32'(res_id),      32'd7);
        chk("lit_j7_sym",     32'(res_sym),     32'h6DB);
        chk("lit_j7_eng_rst", 32'(eng_reset),   32'd0);
        set_best(3'd0, 3'd0, 3'd0, 3'd0);
        res_ready = 1'b1;
        @(negedge Clk);
        res_ready = 1'b0;

        // Job 5 done at 20 with {5,2,7,1}; result held while job 9 waits
        offer(4'd5);
        done_at(20, 3'd5, 3'd2, 3'd7, 3'd1);
        chk("lit_j5_sym",    32'(res_sym),    32'hAB9);
        chk("lit_j5_cycles", 32'(res_cycles), 32'd20);
        fork
            offer(4'd9);
            begin
                repeat (4) @(negedge Clk);
                chk("lit_hold_job_ready", 32'(job_ready), 32'd0);
                chk("lit_hold_sym",       32'(res_sym),   32'hAB9);
                res_ready = 1'b1;
            end
        join
        res_ready = 1'b0;
        chk("lit_j9_busy",  32'(busy),      32'd1);
        chk("lit_j9_popped", 32'(res_valid), 32'd0);
        done_at(4, 3'd1, 3'd1, 3'd1, 3'd1);
        chk("lit_j9_cycles", 32'(res_cycles), 32'd4);
        res_ready = 1'b1;

        // Job 10: eng_done coincides with budget; done wins
        offer(4'd10);
        done_at(MAXC, 3'd1, 3'd2, 3'd3, 3'd4);
        chk("lit_tie_timeout", 32'(res_timeout), 32'd0);
        chk("lit_tie_sym",     32'(res_sym),     32'h29C);
        chk("lit_tie_cycles",  32'(res_cycles),  32'd25);

        // Job 11: reset mid-RUN at cycle 10 aborts with no result
        @(negedge Clk);
        offer(4'd11);
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk("lit_rst_eng_reset", 32'(eng_reset), 32'd0);
        chk("lit_rst_res_valid", 32'(res_valid), 32'd0);
        chk("lit_rst_job_ready", 32'(job_ready), 32'd1);
        chk("lit_rst_busy",      32'(busy),      32'd0);
        repeat (MAXC + 5) @(negedge Clk);
        chk("lit_rst_no_result", 32'(res_valid), 32'd0);

        // Back-to-back jobs 12 and 13 with res_ready held high
        offer(4'd12);
        done_at(3, 3'd7, 3'd0, 3'd0, 3'd6);
        chk("lit_j12_sym", 32'(res_sym), 32'hE06);
        offer(4'd13);
        done_at(2, 3'd2, 3'd4, 3'd6, 3'd0);
        chk("lit_j13_id",     32'(res_id),     32'd13);
        chk("lit_j13_cycles", 32'(res_cycles), 32'd2);
        repeat (3) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dfs_ctrl.md
# dfs_ctrl

Job sequencer for the 4-level exhaustive depth-first sphere-decoding search engine. It accepts detection jobs over a valid/ready handshake and starts the engine by releasing the engine's active-low reset. It captures the best symbol vector on the engine's completion pulse, or aborts on a cycle-budget timeout. It returns tagged results over a second valid/ready handshake. It sits between the job queue and the search engine, and the engine's cost evaluator is fed independently.

## Interface
- ID_W, 4: job tag width
- CYC_W, 16: cycle-counter width
- MAX_CYCLES, 16'd8192: per-job cycle budget; must be ≥ 1
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when job_valid && job_ready
- job_id  in  ID_W  job tag
- eng_reset  out  1  drives the engine Reset (active-low); low holds the engine idle
- eng_done  in  1  engine OutputReady pulse
- eng_best0..eng_best3  in  3 each  engine best-node symbols, valid while eng_done=1
- busy  out  1  high in RUN
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_id  out  ID_W  tag of the finished job
- res_sym  out  12  {best3,best2,best1,best0}
- res_cycles  out  CYC_W  RUN cycles consumed, including the terminating cycle
- res_timeout  out  1  result produced by budget abort

## Operation
- States: IDLE, RUN.
- IDLE
  - eng_reset=0.
  - job_ready = !res_valid || res_ready. This is combinational; the result slot is free or is draining this cycle.
  - On accept: latch job_id, clear cyc_cnt to 0, go to RUN, set eng_reset=1.
- RUN
  - eng_reset=1, job_ready=0, busy=1.
  - Each cycle, cyc_cnt_next = cyc_cnt+1, saturating at all-ones.
  - If eng_done=1: load the result slot with res_sym = eng_best*, res_cycles = cyc_cnt_next, res_timeout=0. Set res_valid=1, eng_reset=0, and go to IDLE.
  - Else if cyc_cnt_next == MAX_CYCLES: load the slot with the current eng_best*, res_cycles = MAX_CYCLES, res_timeout=1. Set res_valid=1, eng_reset=0, and go to IDLE.
  - If eng_done and the budget are reached in the same cycle, eng_done wins and res_timeout=0.
- Result slot
  - Single entry.
  - Cleared (res_valid=0) on a handshake unless it is reloaded the same edge.
  - res_* fields are stable while res_valid=1 && !res_ready.
- Slot-free guarantee: because accept requires a free or draining slot, the slot is always empty during RUN. No capture can be lost.
- eng_done while in IDLE is ignored. It cannot occur, since the engine is held in reset.
- Width rules
  - res_sym packs best0 in [2:0] and best3 in [11:9].
  - cyc_cnt is CYC_W bits, unsigned.
  - MAX_CYCLES is compared at CYC_W bits.

## Timing
- Reset values:
  - state=IDLE
  - eng_reset=0
  - busy=0
  - res_valid=0
  - res_id=0
  - res_sym=0
  - res_cycles=0
  - res_timeout=0
  - job_ready=1 (combinational from res_valid=0)
- Reset mid-RUN aborts the job with no result, and eng_reset drops at the same edge.
- Accept at edge E0. eng_reset and busy are high from E0 to the terminating edge.
- The engine's first search cycle is the cycle after E0; this is cyc_cnt_next=1.
- The engine's final search cycle, where eng_done=1, is cycle N. res_valid rises after that edge with res_cycles=N.
- eng_reset falls on the same edge.
- job_ready can reassert in the first IDLE cycle. With res_ready=1 that cycle, a back-to-back job is accepted, giving a one-cycle idle gap per job.
- Engine timing: the engine restarts itself after OutputReady. The controller drives eng_reset low on the capture edge, so the engine never runs a second search unsupervised.
- The engine clears its best-node registers the edge after eng_done, so capture happens only on the eng_done cycle.

## Test plan
- Real engine, cost input held at all-ones, job_id=3: res_valid after 9 RUN cycles, with res_cycles=9, res_sym=12'h000, res_id=3, res_timeout=0.
- MAX_CYCLES=5, same stimulus, job_id=7: abort with res_cycles=5, res_timeout=1, res_id=7, eng_reset low after the abort edge.
- Engine stub pulsing eng_done at cycle 20 with best={5,2,7,1} (best3..best0): res_sym=12'hAB9 (5→[11:9], 2→[8:6], 7→[5:3], 1→[2:0]), res_cycles=20.
- res_ready held low after a result, job_valid high: job_ready=0 and res_* stable. Raising res_ready gives a pop and an accept on the same edge, and the new job runs.
- Stub asserts eng_done on the same cycle cyc_cnt_next == MAX_CYCLES: res_timeout=0, res_sym=stub value.
- Reset low for one cycle at RUN cycle 10: next cycle shows IDLE, eng_reset=0, res_valid=0, job_ready=1, and no result is emitted.
